// File: rtl/if_fetch_stage.sv
// MIPS instruction-fetch front end: imem req/ack fetcher feeding a 2-entry prefetch FIFO.
// Optional IF_BYPASS_EN forwards an acked word straight to decode when the FIFO is empty.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_stall,
    input  logic        id_branch,
    input  logic [31:0] id_new_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc4,
    output logic [3:0]  if_ins_type,
    output logic [3:0]  if_ins_number
);
    typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

    state_t      state, state_nx;
    logic [31:0] fpc, req_pc;
    logic [31:0] q_inst [2];
    logic [31:0] q_pc4 [2];
    logic [1:0]  cnt, cnt_pop;
    logic [3:0]  tag;
    logic        issue, keep, pop, byp, take, push, valid;
    logic [31:0] new_pc4;
    logic [5:0]  op;

    // occupancy is the registered count, so a same-cycle pop never frees a slot
    assign issue     = (state == IDLE) && (cnt < 2'd2) && !rst;
    assign imem_req  = issue || (state != IDLE);
    assign imem_addr = (state == IDLE) ? fpc : req_pc;
    assign new_pc4   = imem_addr + 32'd4;
    assign keep      = imem_req && imem_ack && !id_branch && (state != DROP);
    assign pop       = (cnt != 2'd0) && !id_stall && !id_branch;
`ifdef IF_BYPASS_EN
    assign byp = (cnt == 2'd0) && (state == WAIT) && imem_ack && !id_branch;
`else
    assign byp = 1'b0;
`endif
    assign take    = byp && !id_stall;
    assign push    = keep && !take;
    assign cnt_pop = cnt - {1'b0, pop};

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (issue && !imem_ack) state_nx = id_branch ? DROP : WAIT;
            WAIT: begin
                if (imem_ack)       state_nx = IDLE;
                else if (id_branch) state_nx = DROP;
            end
            DROP: if (imem_ack) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fpc      <= RESET_PC;
            req_pc   <= RESET_PC;
            cnt      <= 2'd0;
            tag      <= 4'd0;
            q_inst[0] <= '0;
            q_inst[1] <= '0;
            q_pc4[0]  <= '0;
            q_pc4[1]  <= '0;
        end else begin
            if (issue) req_pc <= fpc;
            if (id_branch) fpc <= id_new_pc;
            else if (keep) fpc <= new_pc4;
            if (pop || take) tag <= tag + 4'd1;
            if (id_branch) begin
                cnt <= 2'd0;
            end else begin
                if (pop) begin
                    q_inst[0] <= q_inst[1];
                    q_pc4[0]  <= q_pc4[1];
                end
                // a push lands behind whatever survives this cycle's pop
                if (push) begin
                    if (cnt_pop == 2'd0) begin
                        q_inst[0] <= imem_rdata;
                        q_pc4[0]  <= new_pc4;
                    end else begin
                        q_inst[1] <= imem_rdata;
                        q_pc4[1]  <= new_pc4;
                    end
                end
                cnt <= cnt_pop + {1'b0, push};
            end
        end
    end

    always_comb begin
        valid   = 1'b1;
        if_inst = q_inst[0];
        if_pc4  = q_pc4[0];
        if (cnt == 2'd0) begin
            if (byp) begin
                if_inst = imem_rdata;
                if_pc4  = new_pc4;
            end else begin
                valid   = 1'b0;
                if_inst = '0;
                if_pc4  = '0;
            end
        end
        op          = if_inst[31:26];
        if_ins_type = 4'd0;
        if (valid) begin
            unique case (1'b1)
                op == 6'b000000:     if_ins_type = 4'd1;
                op == 6'b100011:     if_ins_type = 4'd2;
                op == 6'b101011:     if_ins_type = 4'd3;
                op[5:1] == 5'b00010: if_ins_type = 4'd4;
                op[5:1] == 5'b00001: if_ins_type = 4'd5;
                default:             if_ins_type = 4'd6;
            endcase
        end
    end

    assign if_ins_number = tag;
endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: random memory latency, stalls and
// redirects checked against a transaction-level fetch/queue model.
module tb_if_fetch_stage;
    localparam logic [31:0] RPC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst, id_stall, id_branch, imem_req, imem_ack;
    logic [31:0] id_new_pc, imem_addr, imem_rdata, if_inst, if_pc4;
    logic [3:0]  if_ins_type, if_ins_number;

    always #5 clk = ~clk;

    if_fetch_stage #(.RESET_PC(RPC)) dut (
        .clk(clk), .rst(rst), .id_stall(id_stall), .id_branch(id_branch),
        .id_new_pc(id_new_pc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .if_inst(if_inst),
        .if_pc4(if_pc4), .if_ins_type(if_ins_type),
        .if_ins_number(if_ins_number)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } ent_t;

    ent_t        q[$];
    logic [31:0] mem [logic [31:0]];
    int          n_chk = 0;
    int          n_fail = 0;
    bit          pend;
    logic [31:0] pend_addr, npc, tgt;
    int          rem, pend_ep, epoch;
    logic [3:0]  tag;
    int          lat_mode, stall_pct, br_pct;
    bit          br_on_ack, use_tgt;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", nm, got, exp);
        end
    endtask

    function automatic logic [31:0] mword(input logic [31:0] a);
        logic [31:0] r;
        if (!mem.exists(a)) begin
            r = $urandom;
            case ($urandom_range(0, 8))
                0: r[31:26] = 6'h00;
                1: r[31:26] = 6'h23;
                2: r[31:26] = 6'h2b;
                3: r[31:26] = 6'h04;
                4: r[31:26] = 6'h05;
                5: r[31:26] = 6'h02;
                6: r[31:26] = 6'h03;
                7: r = 32'h0;
                default: ;
            endcase
            mem[a] = r;
        end
        return mem[a];
    endfunction

    function automatic logic [3:0] tfun(input logic [31:0] w);
        case (w[31:26])
            6'h00:        return 4'd1;
            6'h23:        return 4'd2;
            6'h2b:        return 4'd3;
            6'h04, 6'h05: return 4'd4;
            6'h02, 6'h03: return 4'd5;
            default:      return 4'd6;
        endcase
    endfunction

    task automatic model_reset();
        q.delete();
        pend    = 1'b0;
        rem     = 0;
        epoch   = 0;
        pend_ep = 0;
        npc     = RPC;
        tag     = 4'd0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            bit          ack, pop, kept;
            logic [31:0] rd;
            ent_t        e;
            id_stall = (int'($urandom_range(0, 99)) < stall_pct);
            chk("req", 32'(imem_req), 32'(pend || (q.size() < 2)));
            if (pend) begin
                chk("addr_hold", imem_addr, pend_addr);
            end else if (imem_req) begin
                chk("addr_new", imem_addr, npc);
                pend      = 1'b1;
                pend_addr = npc;
                pend_ep   = epoch;
                rem = (lat_mode < 0) ? int'($urandom_range(0, 3)) : lat_mode;
            end
            ack = 1'b0;
            rd  = $urandom;
            if (pend) begin
                if (rem == 0) begin
                    ack = 1'b1;
                    rd  = mword(imem_addr);
                end else begin
                    rem--;
                end
            end
            id_branch = br_on_ack ? ack
                      : (int'($urandom_range(0, 99)) < br_pct);
            id_new_pc = use_tgt ? tgt : ($urandom & 32'h0000_03FC);
            imem_ack   = ack;
            imem_rdata = rd;
            #1;
            if (q.size() == 0) begin
                chk("inst_nop", if_inst, 32'h0);
                chk("pc4_nop", if_pc4, 32'h0);
                chk("type_nop", 32'(if_ins_type), 32'h0);
            end else begin
                chk("inst", if_inst, q[0].data);
                chk("pc4", if_pc4, q[0].addr + 32'd4);
                chk("type", 32'(if_ins_type), 32'(tfun(q[0].data)));
            end
            chk("number", 32'(if_ins_number), 32'(tag));
            kept = ack && !id_branch && (pend_ep == epoch);
            pop  = (q.size() > 0) && !id_stall && !id_branch;
            if (ack) pend = 1'b0;
            if (id_branch) begin
                q.delete();
                epoch++;
                npc = id_new_pc;
            end else begin
                if (pop) begin
                    void'(q.pop_front());
                    tag++;
                end
                if (kept) begin
                    e.addr = pend_addr;
                    e.data = mword(pend_addr);
                    q.push_back(e);
                    npc = pend_addr + 32'd4;
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic knobs(input int lat, input int st, input int br,
                         input bit boa, input bit ut, input logic [31:0] t);
        lat_mode  = lat;
        stall_pct = st;
        br_pct    = br;
        br_on_ack = boa;
        use_tgt   = ut;
        tgt       = t;
    endtask

    initial begin
        rst        = 1'b1;
        id_stall   = 1'b0;
        id_branch  = 1'b0;
        id_new_pc  = '0;
        imem_ack   = 1'b0;
        imem_rdata = '0;
        mem[32'h0] = 32'h2001_0005;
        mem[32'h4] = 32'h0022_1820;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", 32'(imem_req), 32'h0);
        chk("rst_addr", imem_addr, RPC);
        chk("rst_inst", if_inst, 32'h0);
        chk("rst_pc4", if_pc4, 32'h0);
        chk("rst_type", 32'(if_ins_type), 32'h0);
        chk("rst_num", 32'(if_ins_number), 32'h0);
        rst = 1'b0;
        #1;
        chk("first_req", 32'(imem_req), 32'h1);
        chk("first_addr", imem_addr, RPC);

        knobs(0, 0, 0, 1'b0, 1'b0, 32'h0);
        run(12);
        knobs(3, 0, 0, 1'b0, 1'b0, 32'h0);
        run(20);
        knobs(0, 100, 0, 1'b0, 1'b0, 32'h0);
        run(4);
        knobs(0, 0, 0, 1'b0, 1'b0, 32'h0);
        run(6);
        knobs(3, 0, 0, 1'b0, 1'b0, 32'h0);
        run(2);
        knobs(3, 0, 100, 1'b0, 1'b1, 32'h0000_0040);
        run(1);
        knobs(3, 0, 0, 1'b0, 1'b0, 32'h0);
        run(14);
        knobs(2, 0, 0, 1'b1, 1'b1, 32'h0000_0100);
        run(5);
        knobs(0, 0, 0, 1'b0, 1'b0, 32'h0);
        run(4);
        knobs(0, 0, 100, 1'b0, 1'b1, 32'hFFFF_FFF8);
        run(1);
        knobs(0, 0, 0, 1'b0, 1'b0, 32'h0);
        run(8);
        knobs(-1, 30, 8, 1'b0, 1'b0, 32'h0);
        run(400);
        knobs(-1, 50, 15, 1'b0, 1'b0, 32'h0);
        run(200);

        knobs(3, 0, 0, 1'b0, 1'b0, 32'h0);
        run(2);
        rst       = 1'b1;
        imem_ack  = 1'b0;
        id_branch = 1'b0;
        #1;
        chk("mid_rst_req", 32'(imem_req), 32'h0);
        chk("mid_rst_addr", imem_addr, RPC);
        chk("mid_rst_inst", if_inst, 32'h0);
        chk("mid_rst_num", 32'(if_ins_number), 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        knobs(-1, 20, 5, 1'b0, 1'b0, 32'h0);
        run(60);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
